// File: rtl/mul_unsigned.sv
// -----------------------------------------------------------------------------
// mul_unsigned
//
// Multi-cycle unsigned shift-add multiplier. Each LOOP cycle retires one
// multiplier bit, LSB first. The loop exits as soon as no set multiplier bits
// remain, so small operands finish quickly. Trivial operands (A==0, B==0,
// B==1) skip the loop entirely.
//
// The handshake is a single-pulse valid_in / valid_out pair. This makes the
// unit interchangeable with the unsigned divider.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous, active-high; forces IDLE and clears registers
//   valid_in     : request strobe, sampled only while ready=1
//   multiplicand : operand A (MULTIPLICAND_WIDTH bits), captured on accept
//   multiplier   : operand B (MULTIPLIER_WIDTH bits), captured on accept
//   ready        : high exactly while IDLE
//   product      : A*B while valid_out=1, otherwise 0
//   valid_out    : one-cycle result pulse
// -----------------------------------------------------------------------------
module mul_unsigned #(
   parameter int MULTIPLICAND_WIDTH = 16,
   parameter int MULTIPLIER_WIDTH   = 8
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         valid_in,
   input  logic [MULTIPLICAND_WIDTH-1:0]                multiplicand,
   input  logic [MULTIPLIER_WIDTH-1:0]                  multiplier,
   output logic                                         ready,
   output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product,
   output logic                                         valid_out
);

   // Product width. An exact A*B always fits in P bits.
   localparam int P = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOP = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                      state;
   state_t                      state_next;
   logic [P-1:0]                acc;
   logic [P-1:0]                mcand;
   logic [MULTIPLIER_WIDTH-1:0] mplier;

   logic                        accept;
   logic                        shortcut;
   logic                        last_iter;
   logic [P-1:0]                a_ext;

   assign a_ext    = {{MULTIPLIER_WIDTH{1'b0}}, multiplicand};
   assign accept   = (state == IDLE) && valid_in;
   assign shortcut = (multiplicand == '0) || (multiplier == '0) ||
                     (multiplier == MULTIPLIER_WIDTH'(1));
   // The current bit is the last one that matters once nothing is set above it.
   assign last_iter = ((mplier >> 1) == '0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = IDLE;
      unique case (state)
         IDLE: begin
            if (valid_in) begin
               state_next = shortcut ? DONE : LOOP;
            end else begin
               state_next = IDLE;
            end
         end
         LOOP: begin
            state_next = last_iter ? DONE : LOOP;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath. Reset clears it so that an aborted operation leaves nothing behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (accept) begin
         // For a shortcut, the result is already known and is parked in acc for DONE.
         if (shortcut && (multiplier == MULTIPLIER_WIDTH'(1))) begin
            acc <= a_ext;
         end else begin
            acc <= '0;
         end
         mcand  <= a_ext;
         mplier <= multiplier;
      end else if (state == LOOP) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         // Bits shifted out of mcand are never needed: the loop ends first.
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   // Outputs are plain decodes of the current state. An illegal state gives all zeros.
   assign ready     = (state == IDLE);
   assign valid_out = (state == DONE);
   assign product   = valid_out ? acc : '0;

endmodule

// File: tb/tb_mul_unsigned.sv
module tb_mul_unsigned;

   localparam int AW = 16;
   localparam int BW = 8;
   localparam int PW = AW + BW;

   logic          clk;
   logic          reset;
   logic          valid_in;
   logic [AW-1:0] multiplicand;
   logic [BW-1:0] multiplier;
   logic          ready;
   logic [PW-1:0] product;
   logic          valid_out;

   int checks   = 0;
   int failures = 0;

   mul_unsigned #(
      .MULTIPLICAND_WIDTH(AW),
      .MULTIPLIER_WIDTH  (BW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .multiplicand(multiplicand),
      .multiplier  (multiplier),
      .ready       (ready),
      .product     (product),
      .valid_out   (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [PW-1:0] p;
      int            lat;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [BW-1:0] b;
   } op_t;

   vec_t vecs[12];
   op_t  pend[$];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference latency: 1 for shortcuts, otherwise (MSB index of B + 1) + 1.
   function automatic int ref_lat(input logic [AW-1:0] a, input logic [BW-1:0] b);
      int k;
      if (a == 0 || b <= 1) return 1;
      k = 0;
      for (int i = 0; i < BW; i++) if (b[i]) k = i + 1;
      return k + 1;
   endfunction

   // Issue one operation, then report product, latency and whether ready is high the cycle after.
   task automatic run_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         output logic [PW-1:0] p, output int lat, output logic rdy_after);
      int n;
      n = 0;
      while (!ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      valid_in     = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(posedge clk);
      #1;
      valid_in     = 1'b0;
      multiplicand = ~a;
      multiplier   = ~b;
      lat = -1;
      p   = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (valid_out) begin
            lat = c;
            p   = product;
            break;
         end
      end
      @(negedge clk);
      rdy_after = ready;
   endtask

   initial begin
      logic [PW-1:0] p;
      int            lat;
      logic          rdy;
      logic [AW-1:0] ra;
      logic [BW-1:0] rb;
      int            accepts;
      int            outs;
      logic          stray;
      op_t           op;

      vecs[0]  = '{16'd7,     8'd5,   24'd35,       4};
      vecs[1]  = '{16'd1000,  8'd200, 24'd200000,   9};
      vecs[2]  = '{16'd65535, 8'd255, 24'd16711425, 9};
      vecs[3]  = '{16'd1234,  8'd0,   24'd0,        1};
      vecs[4]  = '{16'd0,     8'd77,  24'd0,        1};
      vecs[5]  = '{16'd500,   8'd1,   24'd500,      1};
      vecs[6]  = '{16'd65535, 8'd128, 24'd8388480,  9};
      vecs[7]  = '{16'd1,     8'd2,   24'd2,        3};
      vecs[8]  = '{16'd3,     8'd3,   24'd9,        3};
      vecs[9]  = '{16'd100,   8'd2,   24'd200,      3};
      vecs[10] = '{16'd65535, 8'd1,   24'd65535,    1};
      vecs[11] = '{16'd11,    8'd13,  24'd143,      5};

      reset        = 1'b1;
      valid_in     = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", ready, 1);
      check("reset_valid_out", valid_out, 0);
      check("reset_product", product, 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, p, lat, rdy);
         check($sformatf("vec%0d_product", i), p, vecs[i].p);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_ready_after", i), rdy, 1);
      end

      // Product is forced to 0 while no result is presented.
      valid_in     = 1'b1;
      multiplicand = 16'd9;
      multiplier   = 8'd7;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      @(negedge clk);
      check("busy_ready_low", ready, 0);
      check("busy_product_zero", product, 0);
      repeat (6) @(negedge clk);
      check("busy_idle_again", ready, 1);

      // Reset in cycle 3 of 300*129 discards the result.
      valid_in     = 1'b1;
      multiplicand = 16'd300;
      multiplier   = 8'd129;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_ready", ready, 1);
      check("midreset_valid_out", valid_out, 0);
      check("midreset_product", product, 0);
      @(negedge clk);
      reset = 1'b0;
      stray = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (valid_out) stray = 1'b1;
      end
      check("midreset_no_pulse", stray, 0);
      check("midreset_ready_after", ready, 1);
      run_op(16'd3, 8'd4, p, lat, rdy);
      check("post_reset_product", p, 12);
      check("post_reset_latency", lat, 4);

      // valid_in held high with operands changing every cycle.
      accepts = 0;
      outs    = 0;
      pend.delete();
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (valid_out) begin
            outs++;
            if (pend.size() == 0) begin
               check("held_unexpected_pulse", 1, 0);
            end else begin
               op = pend.pop_front();
               check("held_product", product, longint'(op.a) * longint'(op.b));
            end
         end
         ra = AW'($urandom);
         rb = BW'($urandom);
         if (c % 4 == 0) rb = BW'($urandom_range(0, 3));
         multiplicand = ra;
         multiplier   = rb;
         valid_in     = 1'b1;
         if (ready) begin
            pend.push_back('{ra, rb});
            accepts++;
         end
      end
      valid_in = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (valid_out) begin
            outs++;
            if (pend.size() == 0) begin
               check("held_unexpected_pulse", 1, 0);
            end else begin
               op = pend.pop_front();
               check("held_product", product, longint'(op.a) * longint'(op.b));
            end
         end
      end
      check("held_one_pulse_per_accept", outs, accepts);
      check("held_queue_drained", pend.size(), 0);

      // Random sweep against the reference model.
      for (int i = 0; i < 400; i++) begin
         ra = AW'($urandom);
         rb = BW'($urandom);
         if (i % 5 == 0) rb = BW'($urandom_range(0, 6));
         if (i % 37 == 0) ra = '0;
         run_op(ra, rb, p, lat, rdy);
         check("rand_product", p, longint'(ra) * longint'(rb));
         check("rand_latency", lat, ref_lat(ra, rb));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
